// File: rtl/rv_iommu_reg_split64.sv
// Width adapter from the 64-bit IOMMU register request stream to the 32-bit register map.
// Each upstream access becomes up to two 32-bit accesses, low word first. The results are merged into one response.
module rv_iommu_reg_split64 #(
    parameter int ADDR_WIDTH = 56
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    input  logic                  s_write_i,
    input  logic [ADDR_WIDTH-1:0] s_addr_i,
    input  logic [63:0]           s_wdata_i,
    input  logic [7:0]            s_wstrb_i,
    output logic                  s_ready_o,
    output logic [63:0]           s_rdata_o,
    output logic                  s_error_o,
    output logic                  m_valid_o,
    output logic                  m_write_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [31:0]           m_wdata_o,
    output logic [3:0]            m_wstrb_o,
    input  logic [31:0]           m_rdata_i,
    input  logic                  m_error_i,
    input  logic                  m_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_write;
    logic                  r_needHi;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [63:0]           r_wdata;
    logic [7:0]            r_wstrb;
    logic [63:0]           r_rdata;
    logic                  r_err;
    logic                  w_needLo;
    logic                  w_needHi;

    // A read always touches both halves; a write touches only the halves that have strobes set.
    assign w_needLo = ~s_write_i | (|s_wstrb_i[3:0]);
    assign w_needHi = ~s_write_i | (|s_wstrb_i[7:4]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (s_valid_i) begin
                    if (w_needLo)      w_next = LO;
                    else if (w_needHi) w_next = HI;
                    else               w_next = RESP;
                end
            end
            LO: begin
                if (m_ready_i) begin
                    w_next = (m_error_i || !r_needHi) ? RESP : HI;
                end
            end
            HI: begin
                if (m_ready_i) w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Clearing the read data on acceptance makes any skipped half read back as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_write  <= 1'b0;
            r_needHi <= 1'b0;
            r_base   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid_i) begin
                        r_write  <= s_write_i;
                        r_needHi <= w_needHi;
                        r_base   <= s_addr_i & ~ADDR_WIDTH'(7);
                        r_wdata  <= s_wdata_i;
                        r_wstrb  <= s_wstrb_i;
                        r_rdata  <= '0;
                        r_err    <= 1'b0;
                    end
                end
                LO: begin
                    if (m_ready_i) begin
                        r_rdata[31:0] <= m_rdata_i;
                        r_err         <= m_error_i;
                    end
                end
                HI: begin
                    if (m_ready_i) begin
                        r_rdata[63:32] <= m_rdata_i;
                        r_err          <= r_err | m_error_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_rdata_o = r_rdata;
    assign s_error_o = r_err;

    // The downstream signals depend only on the state and the capture registers, so no s_* input reaches m_* combinationally.
    always_comb begin
        s_ready_o = 1'b0;
        m_valid_o = 1'b0;
        m_write_o = 1'b0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_wstrb_o = '0;
        case (r_state)
            LO: begin
                m_valid_o = 1'b1;
                m_write_o = r_write;
                m_addr_o  = r_base;
                m_wdata_o = r_wdata[31:0];
                m_wstrb_o = r_write ? r_wstrb[3:0] : 4'hF;
            end
            HI: begin
                m_valid_o = 1'b1;
                m_write_o = r_write;
                m_addr_o  = r_base + ADDR_WIDTH'(4);
                m_wdata_o = r_wdata[63:32];
                m_wstrb_o = r_write ? r_wstrb[7:4] : 4'hF;
            end
            RESP:    s_ready_o = 1'b1;
            default: ;
        endcase
    end

endmodule
